sym_mapper_upsample: RTL

SYM_MAPPER_UPSAMPLE -- requirements
Module: sym_mapper_upsample

---
 rtl/sym_mapper_upsample.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sym_mapper_upsample.sv
// rtl/sym_mapper_upsample.sv - 4-ASK Gray symbol mapper with 4x zero-stuffed upsampling
module sym_mapper_upsample #(
    parameter int WIDTH   = 22,
    parameter int OUT_W   = 18,
    parameter int LEVEL_A = 32768
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic                    load,
    input  logic [WIDTH-1:0]        lfsr_in,
    output logic signed [OUT_W-1:0] sym_out,
    output logic [1:0]              sym_idx,
    output logic [1:0]              phase,
    output logic [WIDTH-1:0]        sym_count,
    output logic                    wrap,
    output logic                    sync_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Outer level is built directly at OUT_W bits so it cannot wrap for legal LEVEL_A.
    localparam logic signed [OUT_W-1:0] LVL_P1 = OUT_W'(LEVEL_A);
    localparam logic signed [OUT_W-1:0] LVL_P3 = OUT_W'(3 * LEVEL_A);
    localparam logic signed [OUT_W-1:0] LVL_N1 = -LVL_P1;
    localparam logic signed [OUT_W-1:0] LVL_N3 = -LVL_P3;

    // Last count value before wrapping: 2^WIDTH-2, the LFSR period minus one.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    state_t                    state_q, state_d;
    logic signed [OUT_W-1:0]   sym_out_q, sym_out_d;
    logic [1:0]                sym_idx_q, sym_idx_d;
    logic [1:0]                phase_q, phase_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      wrap_q, wrap_d;
    logic                      err_q, err_d;
    logic signed [OUT_W-1:0]   level;
    logic                      sym_edge;

    // Only the two LSBs choose the symbol; the rest of the LFSR word is ignored.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_in[WIDTH-1:2];

    assign sym_edge = sam_clk_en & sym_clk_en;

    // Gray-coded 4-ASK level for the current LFSR symbol bits.
    always_comb begin
        level = LVL_N3;
        case (lfsr_in[1:0])
            2'b00:   level = LVL_N3;
            2'b01:   level = LVL_N1;
            2'b11:   level = LVL_P1;
            default: level = LVL_P3;
        endcase
    end

    // Next-state and output logic: load wins, then symbol edges, then sample edges.
    always_comb begin
        state_d   = state_q;
        sym_out_d = sym_out_q;
        sym_idx_d = sym_idx_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        err_d     = err_q;

        // Symbol enable without a sample enable, or a fifth sample in one symbol.
        if (sym_clk_en && !sam_clk_en) begin
            err_d = 1'b1;
        end
        if ((state_q == ST_RUN) && sam_clk_en && !sym_clk_en && (phase_q == 2'd3)) begin
            err_d = 1'b1;
        end

        if (load) begin
            state_d   = ST_IDLE;
            sym_out_d = '0;
            sym_idx_d = 2'd0;
            phase_d   = 2'd0;
            cnt_d     = '0;
        end else if (sym_edge) begin
            state_d   = ST_RUN;
            sym_out_d = level;
            sym_idx_d = lfsr_in[1:0];
            phase_d   = 2'd0;
            if (state_q == ST_IDLE) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else if ((state_q == ST_RUN) && sam_clk_en) begin
            sym_out_d = '0;
            if (phase_q != 2'd3) begin
                phase_d = phase_q + 2'd1;
            end
        end
    end

    // State and output registers; reset clears everything including the sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sym_out_q <= '0;
            sym_idx_q <= 2'd0;
            phase_q   <= 2'd0;
            cnt_q     <= '0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_out_q <= sym_out_d;
            sym_idx_q <= sym_idx_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
        end
    end

    assign sym_out   = sym_out_q;
    assign sym_idx   = sym_idx_q;
    assign phase     = phase_q;
    assign sym_count = cnt_q;
    assign wrap      = wrap_q;
    assign sync_err  = err_q;

endmodule
